nibble_serial_adder: RTL and testbench
======================================

# nibble_serial_adder

Multi-cycle WIDTH-bit adder that feeds operands one 4-bit nibble per clock into the team's 4-bit ripple-carry adder `rca` and registers the carry between nibbles. It sits directly upstream of `rca`: it sequences `a`/`b`/`cin` into the slice and collects `sum`/`carry` back into a full-width result. It trades latency for area: one 4-bit adder serves any WIDTH, with valid/ready handshakes on both sides.

## Interface
- `WIDTH`, 16: operand/result width in bits. Must be a multiple of 4 and at least 8.
- `NIB`, WIDTH/4: number of nibbles. Derived; do not override.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset. Asynchronous and active-high.
- `in_valid`  in  1  the operands are valid.
- `in_ready`  out  1  the block can accept operands. Equals 1 only in IDLE with `rst` low.
- `a`  in  WIDTH  operand A (unsigned, or two's complement for `ovf`).
- `b`  in  WIDTH  operand B.
- `cin`  in  1  carry-in to nibble 0.
- `out_valid`  out  1  the result is valid. High only in DONE.
- `out_ready`  in  1  the consumer accepts the result.
- `sum`  out  WIDTH  result, a+b+cin mod 2^WIDTH.
- `cout`  out  1  carry out of bit WIDTH-1.
- `ovf`  out  1  signed overflow.

## Operation
- State machine IDLE -> RUN -> DONE -> IDLE. Reset state is IDLE.
- IDLE:
  - On `in_valid && in_ready`, capture `a` and `b` into shift registers, `cin` into the carry register, and the operand MSBs `a[WIDTH-1]`, `b[WIDTH-1]`.
  - Set `idx`=0 and go to RUN. Without a handshake, hold.
- RUN, each cycle:
  - `rca` gets the low nibbles of the A/B shift registers and the carry register.
  - At the edge, the `rca` sum nibble shifts into the top of the sum register (right shift by 4), `rca` carry loads the carry register, A/B shift right by 4, and `idx` increments.
  - When `idx`==NIB-1 at the edge, go to DONE instead.
- DONE:
  - `out_valid`=1. `sum`, `cout` (the carry register) and `ovf` are stable.
  - On `out_ready`, go to IDLE; otherwise hold indefinitely with all outputs unchanged.
- `ovf` = (`a`MSB == `b`MSB) && (`sum[WIDTH-1]` != `a`MSB), evaluated from the registered values.
- Inputs `a`, `b`, `cin` are ignored outside the IDLE handshake. Changing them mid-RUN has no effect.
- `out_ready` is ignored outside DONE.
- `idx` width is clog2(NIB). It never wraps past NIB-1.
- Reset, async at any state including mid-RUN or DONE:
  - State goes to IDLE; `idx`, the shift registers, the carry register and the MSB registers clear to 0.
  - The in-flight operation is discarded. No partial result is ever presented.
  - Reset values: `out_valid`=0, `sum`=0, `cout`=0, `ovf`=0, `in_ready`=0 while `rst` is high, then 1 from the first cycle after deassertion.

## Timing
- Let edge k be the accept edge. Nibble i is computed during the cycle before edge k+1+i.
- `out_valid` rises after edge k+NIB and stays high until the edge where `out_ready` is sampled high.
- Latency is NIB cycles from accept to `out_valid`: 4 cycles for WIDTH=16.
- `in_ready` returns 1 the cycle after result handoff. The earliest next accept is edge k+NIB+2, so peak throughput is one add per NIB+2 cycles.
- No combinational path from `in_valid` to `in_ready` or from `out_ready` to `out_valid`. Both outputs are decoded from the state register only.
- The critical path is one 4-bit ripple through `rca` plus the register setup time.

## Structure
- A shared package `adder_pkg` holds:
  - the state enum `add_state_t` {IDLE, RUN, DONE};
  - the constant `NIB_W`=4.
- Exactly one sub-module: an instance of the existing 4-bit ripple-carry adder `rca`, unmodified.
- The FSM, the shift registers, the carry register and the `ovf` logic live in `nibble_serial_adder`.

## Test plan
- 0x1234 + 0x4321, `cin`=0 -> after 4 cycles `sum`=0x5555, `cout`=0, `ovf`=0.
- 0xFFFF + 0x0001, `cin`=0 -> `sum`=0x0000, `cout`=1, `ovf`=0. This checks carry ripple across all 4 nibble boundaries.
- 0x7FFF + 0x0001 -> `sum`=0x8000, `cout`=0, `ovf`=1. Also 0x8000 + 0x8000 -> `sum`=0x0000, `cout`=1, `ovf`=1.
- 0xFFFF + 0xFFFF, `cin`=1 -> `sum`=0xFFFF, `cout`=1. Hold `out_ready`=0 for 5 cycles -> `out_valid` stays high with outputs stable, and `in_ready`=0 even though `in_valid`=1.
- Assert `rst` asynchronously mid-RUN (`idx`=2) -> outputs are 0 immediately. After release, accept 0x0001 + 0x0002 -> `sum`=0x0003, with no residue from the aborted add.
- Back-to-back: 100 random operand pairs with random `in_valid`/`out_ready` gaps -> every result matches a+b+cin with correct `cout`/`ovf`, and the handshake spacing is never below NIB+2 cycles.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
package adder_pkg;

  // Sequencer states: wait for operands, add one nibble per cycle, present result.
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } add_state_t;

  // Width of the adder slice that is reused on every cycle.
  localparam int NIB_W = 4;

endpackage

// File: rtl/nibble_serial_adder_rca.sv
// 4-bit ripple-carry adder slice.
module rca (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       carry
);

  logic [4:0] c;

  // Chain of full adders, carry rippling from bit 0 upward.
  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < 4; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    carry = c[4];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that reuses one 4-bit rca slice, one nibble per clock,
// with valid/ready handshakes on the operand and result sides.
module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NIB   = WIDTH / NIB_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int IDX_W = $clog2(NIB);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

  add_state_t       state_q;
  add_state_t       state_d;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry_q;
  logic             a_msb;
  logic             b_msb;
  logic [IDX_W-1:0] idx;
  logic [NIB_W-1:0] nib_sum;
  logic             nib_carry;
  logic             accept;

  assign accept = in_valid && (state_q == IDLE);

  rca u_rca (
    .a     (a_sr[NIB_W-1:0]),
    .b     (b_sr[NIB_W-1:0]),
    .cin   (carry_q),
    .sum   (nib_sum),
    .carry (nib_carry)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake/result outputs, decoded from the state register.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    sum       = '0;
    cout      = 1'b0;
    ovf       = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = !rst;
        if (accept) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (idx == IDX_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        sum       = sum_sr;
        cout      = carry_q;
        ovf       = (a_msb == b_msb) && (sum_sr[WIDTH-1] != a_msb);
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, nibble-wise shifting, carry chaining and nibble index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr    <= '0;
      b_sr    <= '0;
      sum_sr  <= '0;
      carry_q <= 1'b0;
      a_msb   <= 1'b0;
      b_msb   <= 1'b0;
      idx     <= '0;
    end else begin
      if (accept) begin
        a_sr    <= a;
        b_sr    <= b;
        carry_q <= cin;
        a_msb   <= a[WIDTH-1];
        b_msb   <= b[WIDTH-1];
        idx     <= '0;
      end else if (state_q == RUN) begin
        // Result nibbles enter at the top so nibble 0 ends up in the low bits.
        sum_sr  <= {nib_sum, sum_sr[WIDTH-1:NIB_W]};
        carry_q <= nib_carry;
        a_sr    <= a_sr >> NIB_W;
        b_sr    <= b_sr >> NIB_W;
        if (idx != IDX_LAST) begin
          idx <= idx + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: directed cases with literal
// expectations plus a reference scoreboard checked on every cycle.
module tb_nibble_serial_adder;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] dut_sum;
  logic             dut_cout;
  logic             dut_ovf;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (dut_sum),
    .cout      (dut_cout),
    .ovf       (dut_ovf)
  );

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             v;
  } res_t;

  res_t exp_q[$];
  int   tests    = 0;
  int   fails    = 0;
  int   cyc      = 0;
  int   acc_cyc  = 0;
  int   last_acc = -1000;

  function automatic res_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic ci);
    res_t         r;
    logic [WIDTH:0] t;
    t   = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
    r.s = t[WIDTH-1:0];
    r.c = t[WIDTH];
    r.v = (x[WIDTH-1] == y[WIDTH-1]) && (t[WIDTH-1] != x[WIDTH-1]);
    return r;
  endfunction

  task automatic chk(input string name, input logic [WIDTH:0] act, input logic [WIDTH:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard bookkeeping at each active edge: record accepts, retire handoffs.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      exp_q.delete();
      last_acc <= -1000;
    end else begin
      if (out_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      if (in_valid && in_ready) begin
        if (last_acc >= 0) chk("accept_spacing", (cyc + 1 - last_acc) >= NIB + 2, 1'b1);
        exp_q.push_back(model(a, b, cin));
        acc_cyc  <= cyc + 1;
        last_acc <= cyc + 1;
      end
    end
  end

  // Per-cycle comparison against the scoreboard, away from the active edge.
  always @(negedge clk) begin
    bit busy;
    busy = (exp_q.size() != 0);
    if (rst) begin
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_in_ready", in_ready, 1'b0);
    end else begin
      chk("in_ready", in_ready, !busy);
      chk("out_valid", out_valid, busy && ((cyc - acc_cyc) >= NIB));
      if (out_valid && busy) begin
        chk("sum", dut_sum, exp_q[0].s);
        chk("cout", dut_cout, exp_q[0].c);
        chk("ovf", dut_ovf, exp_q[0].v);
      end
    end
  end

  // Directed add with literal expectations; called at a falling edge.
  task automatic run_op(input string name, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic ci, input logic [WIDTH-1:0] es, input logic ec,
                        input logic ev, input int hold);
    int n;
    a = x; b = y; cin = ci; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    chk({name, "_accept"}, in_ready, 1'b1);
    @(negedge clk);
    // Scramble operands mid-RUN; they must be ignored.
    a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    chk({name, "_valid"}, out_valid, 1'b1);
    chk({name, "_sum"}, dut_sum, es);
    chk({name, "_cout"}, dut_cout, ec);
    chk({name, "_ovf"}, dut_ovf, ev);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({name, "_hold_valid"}, out_valid, 1'b1);
      chk({name, "_hold_sum"}, dut_sum, es);
      chk({name, "_hold_in_ready"}, in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  initial begin
    bit will_acc;
    int sent;
    int n;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_sum", dut_sum, '0);
    chk("reset_cout", dut_cout, 1'b0);
    chk("reset_ovf", dut_ovf, 1'b0);
    chk("reset_in_ready", in_ready, 1'b0);
    #2 rst = 1'b0;
    @(negedge clk);

    run_op("basic",   16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 0);
    run_op("ripple",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1);
    run_op("posovf",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
    run_op("negovf",  16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 2);
    run_op("allones", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 5);

    // Asynchronous reset in the middle of an add.
    a = 16'h1234; b = 16'h1111; cin = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_sum", dut_sum, '0);
    chk("abort_cout", dut_cout, 1'b0);
    chk("abort_ovf", dut_ovf, 1'b0);
    chk("abort_in_ready", in_ready, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    run_op("after_abort", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 0);

    // Randomised traffic with gaps on both handshakes.
    will_acc = 1'b0;
    sent = 0;
    n = 0;
    while ((sent < 100 || exp_q.size() != 0 || in_valid) && n < 6000) begin
      @(negedge clk);
      n++;
      if (will_acc) begin
        sent++;
        in_valid = 1'b0;
      end
      if (!in_valid && sent < 100 && $urandom_range(0, 2) != 0) begin
        a   = ($urandom_range(0, 4) == 0) ? 16'hFFFF : WIDTH'($urandom);
        b   = ($urandom_range(0, 4) == 0) ? 16'h8000 : WIDTH'($urandom);
        cin = 1'($urandom);
        in_valid = 1'b1;
      end
      will_acc  = in_valid && in_ready;
      out_ready = 1'($urandom_range(0, 1));
    end
    out_ready = 1'b0;
    chk("random_count", WIDTH'(sent), WIDTH'(100));
    chk("random_drained", exp_q.size() == 0, 1'b1);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
